// File: rtl/ifft_4pt_seq.sv
`default_nettype none
// ============================================================================
// Module      : ifft_4pt_seq
// Description : Sequential 4-point inverse DFT on IEEE-754 binary32 complex
//               samples. Collects four frequency-domain samples, runs two
//               radix-2 butterfly stages on a shared bank of four complex
//               adders, scales by 1/4 and streams four time-domain samples.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid/in_ready     - input handshake, in_re/in_im data
//               out_valid/out_ready   - output handshake, out_re/out_im data
//               out_idx               - time index n of the presented sample
//               exc                   - frame contained an exponent-FF input
// Revision    : 1.0 - initial release
// ============================================================================
module ifft_4pt_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_re,
    input  logic [31:0] in_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_re,
    output logic [31:0] out_im,
    output logic [1:0]  out_idx,
    output logic        exc
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  r_idx;
    logic        r_exc;
    // Single sample bank: holds X0..X3, then a,b,c,d, then x0..x3.
    logic [31:0] r_re [4];
    logic [31:0] r_im [4];
    logic [31:0] w_sum_re [4];
    logic [31:0] w_sum_im [4];
    logic [31:0] w_q_re;
    logic [31:0] w_q_im;
    logic        w_accept;
    logic        w_xfer;
    logic        w_in_exc;

    // Binary32 add, round toward zero, denormals flushed, exact zero -> +0,
    // any exponent-FF operand -> +0, overflow saturates to max finite.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big, sml, res;
        logic [7:0]        d;
        logic [4:0]        sh_amt, lz;
        logic [26:0]       m_big, m_sml, m_res, diff;
        logic [53:0]       sh;
        logic [27:0]       sum;
        logic signed [9:0] e_res;
        big = a; sml = b; res = '0; d = '0; sh_amt = '0; lz = '0;
        m_big = '0; m_sml = '0; m_res = '0; diff = '0; sh = '0; sum = '0; e_res = '0;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            res = '0;
        end else if (a[30:23] == 8'h00 && b[30:23] == 8'h00) begin
            res = '0;
        end else if (a[30:23] == 8'h00) begin
            res = b;
        end else if (b[30:23] == 8'h00) begin
            res = a;
        end else begin
            if (a[30:0] < b[30:0]) begin
                big = b;
                sml = a;
            end
            d      = big[30:23] - sml[30:23];
            sh_amt = (d > 8'd27) ? 5'd27 : d[4:0];
            // Three guard bits; everything shifted further folds into a sticky
            // LSB so truncation after subtraction stays exact.
            m_big  = {1'b1, big[22:0], 3'b000};
            sh     = {1'b1, sml[22:0], 3'b000, 27'd0} >> sh_amt;
            m_sml  = {sh[53:28], sh[27] | (|sh[26:0])};
            if (big[31] == sml[31]) begin
                sum = {1'b0, m_big} + {1'b0, m_sml};
                if (sum[27]) begin
                    m_res = {sum[27:2], sum[1] | sum[0]};
                    e_res = $signed({2'b00, big[30:23]}) + 10'sd1;
                end else begin
                    m_res = sum[26:0];
                    e_res = $signed({2'b00, big[30:23]});
                end
            end else begin
                diff = m_big - m_sml;
                for (int i = 0; i < 27; i++) begin
                    if (diff[i]) lz = 5'(26 - i);
                end
                m_res = diff << lz;
                e_res = $signed({2'b00, big[30:23]}) - $signed({5'b00000, lz});
                if (diff == '0) e_res = '0;
            end
            if (e_res >= 10'sd255)
                res = {big[31], 8'hFE, 23'h7FFFFF};
            else if (e_res <= 10'sd0)
                res = '0;
            else
                res = {big[31], e_res[7:0], m_res[25:3]};
        end
        return res;
    endfunction

    // Divide by 4 through the exponent; anything that would go subnormal is zero.
    function automatic logic [31:0] fp_quarter(input logic [31:0] x);
        logic [31:0] res;
        if (x[30:23] <= 8'd2)
            res = '0;
        else
            res = {x[31], x[30:23] - 8'd2, x[22:0]};
        return res;
    endfunction

    function automatic logic [31:0] fp_neg(input logic [31:0] x);
        return {~x[31], x[30:0]};
    endfunction

    assign w_accept = in_valid && (r_state == LOAD);
    assign w_xfer   = out_ready && (r_state == OUT);
    assign w_in_exc = (in_re[30:23] == 8'hFF) || (in_im[30:23] == 8'hFF);
    assign out_idx  = r_idx;
    assign exc      = r_exc;

    // Shared adders. Slots 0/1 always combine entries 0 and 2; slots 2/3
    // combine entry 1 with entry 3, which in S2 is d rotated to j*d.
    always_comb begin
        w_q_re = r_re[3];
        w_q_im = r_im[3];
        if (r_state == S2) begin
            w_q_re = fp_neg(r_im[3]);
            w_q_im = r_re[3];
        end
        w_sum_re[0] = fp_add(r_re[0], r_re[2]);
        w_sum_im[0] = fp_add(r_im[0], r_im[2]);
        w_sum_re[1] = fp_add(r_re[0], fp_neg(r_re[2]));
        w_sum_im[1] = fp_add(r_im[0], fp_neg(r_im[2]));
        w_sum_re[2] = fp_add(r_re[1], w_q_re);
        w_sum_im[2] = fp_add(r_im[1], w_q_im);
        w_sum_re[3] = fp_add(r_re[1], fp_neg(w_q_re));
        w_sum_im[3] = fp_add(r_im[1], fp_neg(w_q_im));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= LOAD;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_re      = '0;
        out_im      = '0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && r_cnt == 2'd3) w_state_nxt = S1;
            end
            S1:   w_state_nxt = S2;
            S2:   w_state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                out_re    = r_re[r_idx];
                out_im    = r_im[r_idx];
                if (out_ready && r_idx == 2'd3) w_state_nxt = LOAD;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_exc <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_re[r_cnt] <= in_re;
                        r_im[r_cnt] <= in_im;
                        r_cnt       <= r_cnt + 2'd1;
                        r_exc       <= ((r_cnt == 2'd0) ? 1'b0 : r_exc) | w_in_exc;
                    end
                end
                S1: begin
                    // a, b, c, d land in entries 0..3
                    for (int i = 0; i < 4; i++) begin
                        r_re[i] <= w_sum_re[i];
                        r_im[i] <= w_sum_im[i];
                    end
                end
                S2: begin
                    // slot order is x0, x2, x1, x3; store in natural order
                    r_re[0] <= fp_quarter(w_sum_re[0]);
                    r_im[0] <= fp_quarter(w_sum_im[0]);
                    r_re[2] <= fp_quarter(w_sum_re[1]);
                    r_im[2] <= fp_quarter(w_sum_im[1]);
                    r_re[1] <= fp_quarter(w_sum_re[2]);
                    r_im[1] <= fp_quarter(w_sum_im[2]);
                    r_re[3] <= fp_quarter(w_sum_re[3]);
                    r_im[3] <= fp_quarter(w_sum_im[3]);
                end
                OUT: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifft_4pt_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifft_4pt_seq
// Description : Self-checking bench for ifft_4pt_seq. Expected outputs are
//               queued when a frame is driven and compared as the DUT
//               presents each output sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifft_4pt_seq;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_re     = '0;
    logic [31:0] in_im     = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_re;
    logic [31:0] out_im;
    logic [1:0]  out_idx;
    logic        exc;

    ifft_4pt_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .exc       (exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic [1:0]  idx;
        logic        exc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] xr [4];
    logic [31:0] xi [4];
    logic [31:0] er [4];
    logic [31:0] ei [4];
    logic        exp_exc;

    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] MONE = 32'hBF800000;
    localparam logic [31:0] FOUR = 32'h40800000;
    localparam logic [31:0] INF  = 32'h7F800000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_frame();
        for (int i = 0; i < 4; i++) begin
            xr[i] = '0; xi[i] = '0; er[i] = '0; ei[i] = '0;
        end
        exp_exc = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_sample(input logic [31:0] re, input logic [31:0] im);
        int n;
        n = 0;
        in_valid = 1'b1; in_re = re; in_im = im;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_re = '0; in_im = '0;
    endtask

    task automatic send_frame();
        for (int k = 0; k < 4; k++)
            sb.push_back({er[k], ei[k], 2'(k), exp_exc});
        for (int k = 0; k < 4; k++)
            send_sample(xr[k], xi[k]);
    endtask

    // stall_at < 0 means no backpressure.
    task automatic drain_frame(input int stall_at);
        exp_t e;
        int   n;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 20) check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
                return;
            end
            e = sb.pop_front();
            if (k == stall_at) begin
                out_ready = 1'b0;
                in_valid = 1'b1; in_re = ONE; in_im = ONE;   // must be ignored
                repeat (3) begin
                    @(posedge clk); #1;
                    check("stall_valid", {31'b0, out_valid}, 32'd1);
                    check("stall_idx", {30'b0, out_idx}, {30'b0, e.idx});
                    check("stall_re", out_re, e.re);
                    check("stall_im", out_im, e.im);
                    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                end
                in_valid = 1'b0; in_re = '0; in_im = '0;
                out_ready = 1'b1;
            end
            check("out_idx", {30'b0, out_idx}, {30'b0, e.idx});
            check("out_re", out_re, e.re);
            check("out_im", out_im, e.im);
            check("exc", {31'b0, exc}, {31'b0, e.exc});
            @(posedge clk); #1;
        end
        check("end_out_valid", {31'b0, out_valid}, 32'd0);
        check("end_in_ready", {31'b0, in_ready}, 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic tone_frame();
        clr_frame();
        xr[1] = FOUR;
        er[0] = ONE;  ei[1] = ONE;  er[2] = MONE; ei[3] = MONE;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_re", out_re, 32'd0);
        check("rst_out_im", out_im, 32'd0);
        check("rst_out_idx", {30'b0, out_idx}, 32'd0);
        check("rst_exc", {31'b0, exc}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // DC input
        clr_frame();
        for (int i = 0; i < 4; i++) xr[i] = ONE;
        er[0] = ONE;
        send_frame();
        drain_frame(-1);

        // Impulse, with output latency check
        clr_frame();
        xr[0] = FOUR;
        for (int i = 0; i < 4; i++) er[i] = ONE;
        send_frame();
        check("latency_c1", {31'b0, out_valid}, 32'd0);
        check("s1_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("latency_c2", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("latency_c3", {31'b0, out_valid}, 32'd1);
        drain_frame(-1);

        // Tone with backpressure at out_idx = 1
        tone_frame();
        send_frame();
        drain_frame(1);

        // Reset after two accepts; partial frame must be discarded
        send_sample(FOUR, INF);
        send_sample(FOUR, FOUR);
        rst_n = 1'b0;
        #2;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_exc", {31'b0, exc}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tone_frame();
        send_frame();
        drain_frame(-1);

        // Exponent-FF input: all outputs zero, exc flagged
        clr_frame();
        xr[0] = INF;
        exp_exc = 1'b1;
        send_frame();
        drain_frame(-1);

        // Next clean frame clears exc
        clr_frame();
        xr[0] = FOUR;
        for (int i = 0; i < 4; i++) er[i] = ONE;
        send_frame();
        drain_frame(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ifft_4pt_seq.md
IFFT_4PT_SEQ -- requirements
Module: ifft_4pt_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_re/in_im carry a valid frequency-domain sample.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts an input sample this cycle.
REQ-005 SHALL have port in_re, input, 32 bits: real part, IEEE-754 binary32.
REQ-006 SHALL have port in_im, input, 32 bits: imaginary part, IEEE-754 binary32.
REQ-007 SHALL have port out_valid, output, 1 bit: out_re/out_im carry a valid time-domain sample.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the output sample this cycle.
REQ-009 SHALL have port out_re, output, 32 bits: real part, binary32.
REQ-010 SHALL have port out_im, output, 32 bits: imaginary part, binary32.
REQ-011 SHALL have port out_idx, output, 2 bits: time index n of the current output sample.
REQ-012 SHALL have port exc, output, 1 bit: current output frame contained an exponent-8'hFF input.

Function
REQ-013 SHALL compute the 4-point inverse DFT x[n] = (1/4) * sum over k of X[k]*W^(-nk), with W^(-1) = +j.
REQ-014 SHALL use radix-2 butterflies (X0..X3 = the four accepted samples):
  - stage 1: a = X0+X2, b = X0-X2, c = X1+X3, d = X1-X3
  - stage 2: x0 = a+c, x2 = a-c, x1 = b + j*d, x3 = b - j*d
  - j*d = (-d_im, d_re); the sign flip is done by inverting bit 31.
REQ-015 SHALL apply the 1/4 scale to every stage-2 result as exponent-2:
  - if the exponent field is <= 2, the result is 32'h00000000
  - a zero input to the scale stays 32'h00000000.
REQ-016 SHALL use binary32 add/sub that is exact when the result is representable and truncates (round toward zero) otherwise.
REQ-017 SHALL flush denormal operands (exponent 0) to zero.
REQ-018 SHALL return exactly 32'h00000000 for any add/sub whose exact result is zero, including x-x.
REQ-019 SHALL force an add/sub result to 32'h00000000 when either operand has exponent 8'hFF.
REQ-020 SHALL implement FSM states LOAD, S1, S2, OUT.
REQ-021 SHALL, in LOAD: assert in_ready = 1; accept a sample on in_valid & in_ready; store it at index cnt, natural order X0..X3.
REQ-022 SHALL move LOAD -> S1 on the 4th accept (cnt = 3), with in_ready = 0 from the next cycle.
REQ-023 SHALL, in S1, register a, b, c, d, then go to S2.
REQ-024 SHALL, in S2, register the scaled x0..x3 into the output buffer, then go to OUT.
REQ-025 SHALL have out_valid = 1 in the cycle three clocks after the cycle of the 4th input accept.
REQ-026 SHALL, in OUT: hold out_valid = 1 and present x[out_idx], starting at out_idx = 0; advance out_idx on out_valid & out_ready.
REQ-027 SHALL keep out_re, out_im and out_idx stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL, on the transfer with out_idx = 3: go to OUT -> LOAD, set out_valid = 0 and in_ready = 1 next cycle, set cnt = 0.
REQ-029 SHALL NOT overlap frames: in_ready = 0 in S1, S2 and OUT.
REQ-030 SHALL ignore in_valid while in_ready = 0.
REQ-031 SHALL ignore out_ready while out_valid = 0.
REQ-032 SHALL set exc when any accepted in_re/in_im has exponent 8'hFF.
REQ-033 SHALL clear exc on the first accept (cnt = 0) of the next frame, and hold it constant during OUT.

Reset
REQ-034 SHALL, while rst_n = 0, immediately force: state LOAD, cnt 0, in_ready 1, out_valid 0, out_re 0, out_im 0, out_idx 0, exc 0.
REQ-035 SHALL discard any partial frame on reset mid-operation; after release, the next accepted sample is X0.

Verification
REQ-036 SHALL verify DC input: X_re = 3F800000 x4, X_im = 0 -> x0 = (3F800000, 0); x1..x3 = (0, 0).
REQ-037 SHALL verify impulse: X0 = 40800000, others 0 -> x0..x3 all = (3F800000, 0); out_valid rises 3 cycles after the 4th accept.
REQ-038 SHALL verify tone: X1 = 40800000, others 0 -> x0 = (3F800000, 0), x1 = (0, 3F800000), x2 = (BF800000, 0), x3 = (0, BF800000).
REQ-039 SHALL verify backpressure: out_ready = 0 for 3 cycles at out_idx = 1 -> outputs and out_idx hold; in_ready stays 0; all four samples transfer exactly once.
REQ-040 SHALL verify reset mid-frame: rst_n pulsed low after 2 accepts -> in_ready = 1, out_valid = 0; the next 4 samples from REQ-038 yield the REQ-038 outputs.
REQ-041 SHALL verify exception: X0 re = 7F800000, others 0 -> exc = 1 for the frame; all out_re = 0; the next clean frame has exc = 0.
